// File: rtl/module_keypad_encoder.sv
// module_keypad_encoder
// Scans a 4x4 active-low matrix keypad one column at a time, debounces the
// sampled rows and presents the accepted key as {row_idx, col_idx} on a
// valid/ready handshake. Each physical press yields exactly one key_valid.
//
// Optional feature: define MULTIKEY_ERR_EN to reject multi-row presses with a
// one-cycle multi_key pulse. When undefined, multi_key is tied low and the
// lowest-index row wins.
//
// Parameters
//   SCAN_DIV        clocks per column slot (>=2)
//   DEBOUNCE_SCANS  matching tick samples needed to accept a press or a
//                   release (1..15)
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   stop       in   freeze divider, column and scan FSM
//   row_n[3:0] in   keypad rows, active-low, asynchronous to clk
//   col_n[3:0] out  one-hot active-low column drive
//   key_code   out  {row_idx[1:0], col_idx[1:0]} of the accepted key
//   key_valid  out  key_code valid, held until key_ready
//   key_ready  in   consumer accepts key_code
//   multi_key  out  one-cycle pulse on a multi-row sample (MULTIKEY_ERR_EN)
module module_keypad_encoder #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stop,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       multi_key
);

  localparam int unsigned DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W    = 4;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_MAX   = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_VALID    = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  // Registers
  logic [3:0]       sync1_q, sync2_q;
  logic [DIV_W-1:0] div_q, div_d;
  state_e           state_q, state_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_n_q, col_n_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             multi_key_q, multi_key_d;

  // Combinational helpers
  logic [3:0]       rows_s;
  logic             tick;
  logic             hit;
  logic [1:0]       row_idx;
  logic [CNT_W-1:0] cnt_inc;
`ifdef MULTIKEY_ERR_EN
  logic [3:0]       rows_low;
  logic             multi;
`endif

  assign rows_s  = sync2_q;
  assign hit     = ~&rows_s;
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Two-stage synchronizer for the asynchronous keypad rows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
    end else begin
      sync1_q <= row_n;
      sync2_q <= sync1_q;
    end
  end

  // Column slot divider; tick is the last count of a slot while running
  assign tick = !stop && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    if (!stop) begin
      if (div_q == DIV_LAST) div_d = '0;
      else                   div_d = div_q + DIV_W'(1);
    end
  end

  // Priority encoder: lowest-index active row wins
  always_comb begin
    row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows_s[i]) row_idx = 2'(i);
    end
  end

`ifdef MULTIKEY_ERR_EN
  // More than one row low: clearing the lowest set bit leaves something
  assign rows_low = ~rows_s;
  assign multi    = |(rows_low & (rows_low - 4'd1));
`endif

  // Scan FSM next-state and datapath
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    multi_key_d = 1'b0;

    unique case (state_q)
      ST_SCAN: begin
        if (tick) begin
`ifdef MULTIKEY_ERR_EN
          if (multi) begin
            multi_key_d = 1'b1;
            cnt_d       = '0;
          end else
`endif
          if (hit) begin
            cand_d = {row_idx, col_idx_q};
            cnt_d  = CNT_W'(1);
            if (DEBOUNCE_SCANS == 1) begin
              key_code_d  = {row_idx, col_idx_q};
              key_valid_d = 1'b1;
              state_d     = ST_VALID;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
      end

      ST_DEBOUNCE: begin
        if (tick) begin
`ifdef MULTIKEY_ERR_EN
          if (multi) begin
            multi_key_d = 1'b1;
            cnt_d       = '0;
            state_d     = ST_SCAN;
          end else
`endif
          if (hit && ({row_idx, col_idx_q} == cand_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_MAX) begin
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              state_d     = ST_VALID;
            end
          end else begin
            // Bounce or a different key: restart on the same column
            cnt_d   = '0;
            state_d = ST_SCAN;
          end
        end
      end

      ST_VALID: begin
        // Handshake completes even while stopped
        if (key_valid_q && key_ready) begin
          key_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (tick) begin
          if (hit) begin
            cnt_d = '0;
          end else if (cnt_inc == DB_MAX) begin
            cnt_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = ST_SCAN;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      default: state_d = ST_SCAN;
    endcase

    col_n_d = ~(4'b0001 << col_idx_d);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q       <= '0;
      state_q     <= ST_SCAN;
      col_idx_q   <= 2'd0;
      col_n_q     <= 4'b1110;
      cand_q      <= 4'd0;
      cnt_q       <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      multi_key_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      col_n_q     <= col_n_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      multi_key_q <= multi_key_d;
    end
  end

  assign col_n     = col_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign multi_key = multi_key_q;

endmodule

// File: tb/tb_module_keypad_encoder.sv
// Directed bench for module_keypad_encoder with SCAN_DIV=4, DEBOUNCE_SCANS=2.
// A behavioural keypad matrix drives row_n from col_n and a pressed-key map.
module tb_module_keypad_encoder;

  logic       clk;
  logic       rst;
  logic       stop;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       multi_key;

  // keys[row*4+col] = 1 when that key is pressed
  logic [15:0] keys;

  int n_vec;
  int n_err;
  int vrise;
  logic prev_v;

  module_keypad_encoder #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stop     (stop),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .multi_key(multi_key)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Keypad matrix: a row is pulled low if a pressed key sits on a driven column
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
      end
    end
  end

  // Count key_valid rising edges
  always @(negedge clk) begin
    if (rst) begin
      vrise  <= 0;
      prev_v <= 1'b0;
    end else begin
      if (key_valid && !prev_v) vrise <= vrise + 1;
      prev_v <= key_valid;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n;
    n = 0;
    while (!key_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, 8'(key_valid), 8'd1);
  endtask

  task automatic wait_col(input string tag, input logic [3:0] c, input int max);
    int n;
    n = 0;
    while (col_n !== c && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, 8'(col_n), 8'(c));
  endtask

  logic [3:0] seq [4];
  int         snap;
  int         n;
  logic [3:0] prev;
  logic       found;

  initial begin
    n_vec = 0;
    n_err = 0;
    seq[0] = 4'hD; seq[1] = 4'hB; seq[2] = 4'h7; seq[3] = 4'hE;
    rst = 1'b1; stop = 1'b0; key_ready = 1'b0; keys = 16'h0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_col_n", 8'(col_n), 8'h0E);
    check("rst_valid", 8'(key_valid), 8'h00);
    check("rst_code", 8'(key_code), 8'h00);
    check("rst_multi", 8'(multi_key), 8'h00);

    // Idle scan: one column step every 4 clocks
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      prev = col_n;
      do begin
        @(negedge clk);
        n++;
      end while (col_n == prev && n < 20);
      check("col_seq", 8'(col_n), 8'(seq[i]));
      check("col_period", 8'(n), 8'd4);
    end

    // Press row2/col1 and hold
    wait_col("wait_col1", 4'hD, 40);
    keys[9] = 1'b1;
    wait_valid("press_valid", 40);
    check("press_code", 8'(key_code), 8'h09);
    check("press_col_frozen", 8'(col_n), 8'h0D);
    repeat (10) @(negedge clk);
    check("hold_valid", 8'(key_valid), 8'h01);
    check("hold_code", 8'(key_code), 8'h09);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    check("handshake_drop", 8'(key_valid), 8'h00);
    snap = vrise;
    repeat (40) @(negedge clk);
    check("no_repeat", 8'(vrise - snap), 8'h00);
    check("release_col_frozen", 8'(col_n), 8'h0D);
    keys = 16'h0;
    wait_col("resume_col2", 4'hB, 40);

    // Bounce: key on col3 seen by one tick only
    wait_col("wait_col3", 4'h7, 40);
    snap = vrise;
    keys[3] = 1'b1;
    repeat (4) @(negedge clk);
    keys[3] = 1'b0;
    wait_col("bounce_scan_on", 4'hE, 40);
    check("bounce_no_valid", 8'(vrise - snap), 8'h00);

    // key_ready held high: key_valid lasts one cycle
    key_ready = 1'b1;
    wait_col("wait_col2", 4'hB, 40);
    keys[6] = 1'b1;
    wait_valid("rdy_valid", 40);
    check("rdy_code", 8'(key_code), 8'h06);
    @(negedge clk);
    check("rdy_one_cycle", 8'(key_valid), 8'h00);
    key_ready = 1'b0;
    keys = 16'h0;
    wait_col("rdy_resume", 4'h7, 60);

    // stop during DEBOUNCE on row3/col3
    keys[15] = 1'b1;
    repeat (5) @(negedge clk);
    stop = 1'b1;
    repeat (20) @(negedge clk);
    check("stop_col", 8'(col_n), 8'h07);
    check("stop_no_valid", 8'(key_valid), 8'h00);
    stop = 1'b0;
    wait_valid("stop_valid", 20);
    check("stop_code", 8'(key_code), 8'h0F);
    check("stop_col_after", 8'(col_n), 8'h07);
    stop = 1'b1;
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    check("stop_handshake", 8'(key_valid), 8'h00);
    stop = 1'b0;
    keys = 16'h0;
    wait_col("stop_resume", 4'hE, 60);

    // Rows 1 and 3 on col0
    keys[4] = 1'b1;
    keys[12] = 1'b1;
`ifdef MULTIKEY_ERR_EN
    snap = vrise;
    found = 1'b0;
    n = 0;
    while (!found && n < 40) begin
      @(negedge clk);
      if (multi_key) found = 1'b1;
      n++;
    end
    check("multi_pulse", 8'(found), 8'h01);
    @(negedge clk);
    check("multi_one_cycle", 8'(multi_key), 8'h00);
    repeat (20) @(negedge clk);
    check("multi_no_valid", 8'(vrise - snap), 8'h00);
    keys = 16'h0;
    wait_col("multi_resume", 4'hD, 60);
`else
    found = 1'b0;
    wait_valid("multi_valid", 40);
    check("multi_code", 8'(key_code), 8'h04);
    check("multi_tied", 8'(multi_key), 8'h00);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    keys = 16'h0;
    wait_col("multi_resume", 4'hD, 60);
`endif

    // Reset while VALID clears key_valid asynchronously
    keys[9] = 1'b1;
    wait_valid("prerst_valid", 40);
    #3 rst = 1'b1;
    #1;
    check("async_rst_valid", 8'(key_valid), 8'h00);
    check("async_rst_col", 8'(col_n), 8'h0E);
    check("async_rst_code", 8'(key_code), 8'h00);
    keys = 16'h0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
